// File: rtl/bootrom_reg_bridge.sv
// Boot ROM front-end: register-interface bus to a synchronous ROM macro.
// A bus word may span several ROM words; one ROM read is issued per slice
// and the slices are assembled little-endian into the response. Writes and
// out-of-range addresses are answered with an error and never touch the ROM.
module bootrom_reg_bridge #(
  parameter int unsigned AddrWidth  = 64,
  parameter int unsigned BusWidth   = 64,
  parameter int unsigned RomWidth   = 32,
  parameter int unsigned RomDepth   = 1024,
  parameter int unsigned RomLatency = 1,
  parameter logic [AddrWidth-1:0] BaseAddr = '0,
  localparam int unsigned RomAw     = $clog2(RomDepth)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  reg_valid_i,
  input  logic                  reg_write_i,
  input  logic [AddrWidth-1:0]  reg_addr_i,
  input  logic [BusWidth-1:0]   reg_wdata_i,
  input  logic [BusWidth/8-1:0] reg_wstrb_i,
  output logic                  reg_ready_o,
  output logic [BusWidth-1:0]   reg_rdata_o,
  output logic                  reg_error_o,
  output logic                  rom_req_o,
  output logic [RomAw-1:0]      rom_addr_o,
  input  logic [RomWidth-1:0]   rom_rdata_i
);

  localparam int unsigned Ratio   = BusWidth / RomWidth;
  localparam int unsigned RatioSh = $clog2(Ratio);
  localparam int unsigned ByteAw  = $clog2(BusWidth / 8);
  localparam int unsigned BeatW   = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam int unsigned CntW    = $clog2(RomLatency + 1);

  localparam logic [AddrWidth-1:0] RomBytes = AddrWidth'(RomDepth * RomWidth / 8);
  localparam logic [BeatW-1:0]     LastBeat = BeatW'(Ratio - 1);
  localparam logic [CntW-1:0]      LatLoad  = CntW'(RomLatency);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, ERR} state_e;

  state_e                state_q, state_d;
  logic [BeatW-1:0]      beat_q;
  logic [CntW-1:0]       cnt_q;
  logic [RomAw-1:0]      base_q;
  logic [RomAw-1:0]      rom_addr_q;
  logic [BusWidth-1:0]   buf_q;
  logic [BusWidth-1:0]   rdata_q;
  logic [BusWidth-1:0]   asm_d;

  logic [AddrWidth-1:0]  offset;
  logic [AddrWidth-1:0]  idx_full;
  logic                  in_range;
  logic                  bad_req;
  logic                  cap;
  logic                  last;
  logic                  unused_bits;

  // Address decode: word-aligned ROM index of the first slice, plus range check.
  assign offset   = reg_addr_i - BaseAddr;
  assign idx_full = (offset >> ByteAw) << RatioSh;
  assign in_range = (reg_addr_i >= BaseAddr) && (offset < RomBytes);
  assign bad_req  = reg_write_i || !in_range;

  // Capture happens in the WAIT cycle where the counter steps from 1 to 0.
  assign cap  = (state_q == WAIT) && (cnt_q == CntW'(1));
  assign last = (beat_q == LastBeat);

  assign unused_bits = ^{reg_wdata_i, reg_wstrb_i, idx_full[AddrWidth-1:RomAw]};

  // Merge the incoming ROM word into its little-endian slot of the bus word.
  always_comb begin
    asm_d = buf_q;
    asm_d[int'(beat_q)*RomWidth +: RomWidth] = rom_rdata_i;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (reg_valid_i) state_d = bad_req ? ERR : REQ;
      REQ:       state_d = WAIT;
      WAIT:      if (cap) state_d = last ? RESP : REQ;
      RESP, ERR: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath: beat/latency counters, ROM address, slice assembly, response word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q     <= '0;
      cnt_q      <= '0;
      base_q     <= '0;
      rom_addr_q <= '0;
      buf_q      <= '0;
      rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (reg_valid_i) begin
          beat_q <= '0;
          base_q <= idx_full[RomAw-1:0];
          if (bad_req) rdata_q    <= '0;
          else         rom_addr_q <= idx_full[RomAw-1:0];
        end
        REQ: cnt_q <= LatLoad;
        WAIT: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cap) begin
            buf_q <= asm_d;
            if (last) begin
              rdata_q <= asm_d;
            end else begin
              beat_q     <= beat_q + BeatW'(1);
              rom_addr_q <= base_q + RomAw'(beat_q + BeatW'(1));
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs come straight from the state register or datapath registers.
  assign rom_req_o   = (state_q == REQ);
  assign rom_addr_o  = rom_addr_q;
  assign reg_ready_o = (state_q == RESP) || (state_q == ERR);
  assign reg_error_o = (state_q == ERR);
  assign reg_rdata_o = rdata_q;

endmodule

// File: tb/tb_bootrom_reg_bridge.sv
// Bench for bootrom_reg_bridge: two instances (64/32 ratio 2, latency 1 and
// 32/32 ratio 1, latency 3) against a cycle-indexed expectation model.
module tb_bootrom_reg_bridge;

  localparam int NCYC = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n [2];
  logic        v     [2];
  logic        w     [2];
  logic [63:0] a     [2];
  logic        rdy   [2];
  logic        er    [2];
  logic        req   [2];
  logic [3:0]  ra    [2];
  logic [31:0] romd  [2];
  logic [63:0] rd0;
  logic [31:0] rd1;
  logic [1:0][63:0] rdv;

  assign rdv[0] = rd0;
  assign rdv[1] = {32'h0, rd1};

  bootrom_reg_bridge #(
    .AddrWidth(64), .BusWidth(64), .RomWidth(32), .RomDepth(16),
    .RomLatency(1), .BaseAddr(64'h10000)
  ) dut0 (
    .clk_i(clk), .rst_ni(rst_n[0]), .reg_valid_i(v[0]), .reg_write_i(w[0]),
    .reg_addr_i(a[0]), .reg_wdata_i(64'h0), .reg_wstrb_i(8'h0),
    .reg_ready_o(rdy[0]), .reg_rdata_o(rd0), .reg_error_o(er[0]),
    .rom_req_o(req[0]), .rom_addr_o(ra[0]), .rom_rdata_i(romd[0])
  );

  bootrom_reg_bridge #(
    .AddrWidth(64), .BusWidth(32), .RomWidth(32), .RomDepth(16),
    .RomLatency(3), .BaseAddr(64'h10000)
  ) dut1 (
    .clk_i(clk), .rst_ni(rst_n[1]), .reg_valid_i(v[1]), .reg_write_i(w[1]),
    .reg_addr_i(a[1]), .reg_wdata_i(32'h0), .reg_wstrb_i(4'h0),
    .reg_ready_o(rdy[1]), .reg_rdata_o(rd1), .reg_error_o(er[1]),
    .rom_req_o(req[1]), .rom_addr_o(ra[1]), .rom_rdata_i(romd[1])
  );

  function automatic int ratio_of(int d); return (d == 0) ? 2 : 1; endfunction
  function automatic int lat_of(int d);   return (d == 0) ? 1 : 3; endfunction

  // ROM macros: word i = 0xB000_0000 + i, valid exactly latency cycles after req.
  logic        pv [2][3];
  logic [31:0] pd [2][3];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int s = 2; s > 0; s--) begin
        pv[d][s] <= pv[d][s-1];
        pd[d][s] <= pd[d][s-1];
      end
      pv[d][0] <= req[d];
      pd[d][0] <= 32'hB000_0000 + 32'(ra[d]);
    end
  end
  assign romd[0] = (pv[0][0] === 1'b1) ? pd[0][0] : 32'hDEAD_BEEF;
  assign romd[1] = (pv[1][2] === 1'b1) ? pd[1][2] : 32'hDEAD_BEEF;

  // Expectation model indexed by cycle number.
  logic        m_rdy [2][NCYC];
  logic        m_err [2][NCYC];
  logic [63:0] m_rd  [2][NCYC];
  logic        m_req [2][NCYC];
  logic [3:0]  m_ad  [2][NCYC];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(int d, string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL dut%0d %s @cyc %0d: got %h want %h", d, nm, cyc, act, exp);
    end
  endtask

  task automatic clear_model(int d);
    for (int i = 0; i < NCYC; i++) begin
      m_rdy[d][i] = 1'b0; m_err[d][i] = 1'b0; m_rd[d][i] = '0;
      m_req[d][i] = 1'b0; m_ad[d][i]  = '0;
    end
  endtask

  // What the bridge must do for a request accepted at cycle t.
  task automatic model(int d, bit wr, logic [63:0] addr, int t);
    int ratio;
    int lat;
    int idx;
    int c;
    logic [63:0] word;
    logic [31:0] wv;
    ratio = ratio_of(d);
    lat   = lat_of(d);
    if (wr || addr < 64'h10000 || (addr - 64'h10000) >= 64'd64) begin
      m_rdy[d][t+1] = 1'b1; m_err[d][t+1] = 1'b1; m_rd[d][t+1] = '0;
    end else begin
      idx  = int'((addr - 64'h10000) / 64'(ratio * 4)) * ratio;
      word = '0;
      for (int k = 0; k < ratio; k++) begin
        c = t + 1 + k * (1 + lat);
        m_req[d][c] = 1'b1;
        m_ad[d][c]  = 4'(idx + k);
        wv   = 32'hB000_0000 + 32'(idx + k);
        word = word | ({32'h0, wv} << (32 * k));
      end
      c = t + 1 + ratio * (1 + lat);
      m_rdy[d][c] = 1'b1; m_err[d][c] = 1'b0; m_rd[d][c] = word;
    end
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n[d] !== 1'b1) begin
        chk(d, "reset_ctl", {59'h0, rdy[d], er[d], req[d], ra[d]} , 64'h0);
        chk(d, "reset_rdata", rdv[d], 64'h0);
      end else if (cyc < NCYC) begin
        chk(d, "ready", {63'h0, rdy[d]}, {63'h0, m_rdy[d][cyc]});
        if (m_rdy[d][cyc]) begin
          chk(d, "rdata", rdv[d], m_rd[d][cyc]);
          chk(d, "error", {63'h0, er[d]}, {63'h0, m_err[d][cyc]});
        end
        chk(d, "rom_req", {63'h0, req[d]}, {63'h0, m_req[d][cyc]});
        if (m_req[d][cyc]) chk(d, "rom_addr", {60'h0, ra[d]}, {60'h0, m_ad[d][cyc]});
      end
    end
  end

  // One transaction with hand-computed response data and latency.
  task automatic xact(int d, bit wr, logic [63:0] addr, logic [63:0] exp_rd,
                      bit exp_err, int exp_lat, string nm);
    int t;
    bit got;
    int lat;
    logic [63:0] rdq;
    logic erq;
    @(posedge clk); #1;
    t = cyc;
    model(d, wr, addr, t);
    w[d] = wr; a[d] = addr; v[d] = 1'b1;
    got = 1'b0; lat = 0; rdq = '0; erq = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy[d] === 1'b1) begin
        got = 1'b1; lat = cyc - t; rdq = rdv[d]; erq = er[d];
        break;
      end
    end
    chk(d, {nm, "_got_ready"}, {63'h0, got}, 64'h1);
    if (got) begin
      chk(d, {nm, "_latency"}, 64'(lat), 64'(exp_lat));
      chk(d, {nm, "_rdata"}, rdq, exp_rd);
      chk(d, {nm, "_error"}, {63'h0, erq}, {63'h0, exp_err});
    end
    @(posedge clk); #1;
    v[d] = 1'b0; w[d] = 1'b0;
  endtask

  initial begin
    int t;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; v[d] = 1'b0; w[d] = 1'b0; a[d] = '0;
      clear_model(d);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    repeat (4) @(posedge clk);

    // Ratio 2, latency 1.
    xact(0, 1'b0, 64'h10008, 64'hB000_0003_B000_0002, 1'b0, 5, "rd_10008");
    xact(0, 1'b0, 64'h1000C, 64'hB000_0003_B000_0002, 1'b0, 5, "rd_1000C");
    xact(0, 1'b0, 64'h10038, 64'hB000_000F_B000_000E, 1'b0, 5, "rd_last");
    xact(0, 1'b0, 64'h10040, 64'h0, 1'b1, 1, "rd_above");
    xact(0, 1'b0, 64'h0FFF8, 64'h0, 1'b1, 1, "rd_below");
    xact(0, 1'b1, 64'h10000, 64'h0, 1'b1, 1, "wr_base");
    xact(0, 1'b0, 64'h10010, 64'hB000_0005_B000_0004, 1'b0, 5, "rd_10010");

    // Abort: reset lands in WAIT of beat 0; no response may follow.
    @(posedge clk); #1;
    t = cyc;
    model(0, 1'b0, 64'h10000, t);
    a[0] = 64'h10000; v[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n[0] = 1'b0; v[0] = 1'b0;
    clear_model(0);
    repeat (2) @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    repeat (6) @(posedge clk);
    xact(0, 1'b0, 64'h10000, 64'hB000_0001_B000_0000, 1'b0, 5, "rd_after_abort");

    // Ratio 1, latency 3.
    xact(1, 1'b0, 64'h10004, 64'hB000_0001, 1'b0, 5, "lat3_rd_10004");
    xact(1, 1'b0, 64'h1003C, 64'hB000_000F, 1'b0, 5, "lat3_rd_last");
    xact(1, 1'b0, 64'h10040, 64'h0, 1'b1, 1, "lat3_rd_above");

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bootrom_reg_bridge.md
# bootrom_reg_bridge

Parametrised boot ROM front-end between the register-interface bus and a synchronous ROM macro with configurable read latency. It replaces the combinational single-width boot ROM hookup. Bus width may be a power-of-two multiple of the ROM word width; the block sequences one ROM read per slice and assembles the bus word. It also range-checks addresses and returns an error response for writes and out-of-range accesses.

## Interface
- AddrWidth, 64: bus address width.
- BusWidth, 64: bus data width. Must be a power of two and ≥ RomWidth.
- RomWidth, 32: ROM word width. Ratio = BusWidth/RomWidth and must be a power of two ≥1.
- RomDepth, 1024: number of ROM words. RomAw = $clog2(RomDepth).
- RomLatency, 1: cycles from rom_req_o to valid rom_rdata_i. Must be ≥1.
- BaseAddr, 64'h0: bus base address of the ROM.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- reg_valid_i  in  1  request valid; held until reg_ready_o.
- reg_write_i  in  1  1 = write.
- reg_addr_i  in  AddrWidth  byte address.
- reg_wdata_i  in  BusWidth  ignored.
- reg_wstrb_i  in  BusWidth/8  ignored.
- reg_ready_o  out  1  one-cycle response strobe.
- reg_rdata_o  out  BusWidth  read data, valid with reg_ready_o.
- reg_error_o  out  1  error, valid with reg_ready_o.
- rom_req_o  out  1  ROM read strobe.
- rom_addr_o  out  RomAw  ROM word index.
- rom_rdata_i  in  RomWidth  ROM data, sampled RomLatency cycles after rom_req_o.

## Operation
- Definitions:
  - offset = reg_addr_i − BaseAddr, computed at AddrWidth bits.
  - The low $clog2(BusWidth/8) address bits are ignored, so access is bus-word aligned.
  - Base index = (offset >> $clog2(BusWidth/8)) * Ratio.
- In range means reg_addr_i ≥ BaseAddr and offset < RomDepth*RomWidth/8.
- FSM states: IDLE, REQ, WAIT, RESP, ERR.
- IDLE, on reg_valid_i:
  - Latch the address and clear the beat counter.
  - Write, or out-of-range → ERR.
  - Otherwise → REQ.
- REQ:
  - rom_req_o=1, rom_addr_o = base index + beat.
  - Load the latency counter with RomLatency. → WAIT.
- WAIT:
  - Decrement the counter.
  - When it reaches 0, capture rom_rdata_i into reg_rdata_o[beat*RomWidth +: RomWidth] (little-endian slice order).
  - If beat < Ratio−1: beat++ → REQ. Else → RESP.
- RESP: reg_ready_o=1, reg_error_o=0. → IDLE.
- ERR:
  - reg_ready_o=1, reg_error_o=1, reg_rdata_o=0.
  - No ROM access occurs. → IDLE.
- A request is never accepted in the cycle reg_ready_o is high. IDLE re-evaluates reg_valid_i on the following cycle.
- If reg_valid_i drops mid-transaction, that is a protocol violation. The transaction still completes and reg_ready_o still pulses.
- rom_addr_o holds its last value while rom_req_o=0.
- reg_rdata_o holds its last value outside RESP.

## Timing
- Reset values: all outputs 0, state IDLE, beat 0, counter 0.
- Reset asserted mid-transaction aborts immediately. No ready pulse is emitted for the aborted request.
- Read latency:
  - Valid seen in IDLE at cycle t gives reg_ready_o at t+1+Ratio*(1+RomLatency).
  - Example: Ratio=2, RomLatency=1 gives t+5.
- Error latency: reg_ready_o at t+1.
- reg_ready_o is exactly one cycle wide. Throughput is one transaction in flight.
- All outputs are registered or decoded from the state register only. There is no combinational path from reg_*_i to any output.

## Test plan
Default config: BusWidth=64, RomWidth=32, RomDepth=16, RomLatency=1, BaseAddr=0x10000. ROM model: word i = 0xB000_0000+i.
- Reset check: hold rst_ni=0 → all outputs 0. After release, with no valid, rom_req_o stays 0.
- Aligned read: read 0x10008 at cycle t →
  - rom_req_o at t+1 with addr 2, and at t+3 with addr 3.
  - reg_ready_o at t+5 only, with rdata=0xB000_0003_B000_0002 and error=0.
- Unaligned and last-word reads:
  - Read 0x1000C → same response as 0x10008.
  - Read 0x10038 → rdata=0xB000_000F_B000_000E.
- Range errors: each of the following gives ready at t+1 with error=1, rdata=0, and no rom_req_o:
  - read 0x10040
  - read 0x0FFF8
  - write 0x10000
- Abort: pull rst_ni low in WAIT of beat 0 → all outputs 0, no ready pulse. A following read of 0x10000 returns 0xB000_0001_B000_0000.
- Latency and ratio config: RomLatency=3, BusWidth=32. Read 0x10004 at t → rom_req_o at t+1 with addr 1; ready at t+5 with rdata=0xB000_0001.
